ex_muldiv: RTL and testbench

Iterative multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register. It consumes the decoded MULT/MULTU/DIV/DIVU operation and the rs/rt operands, owns the architectural HI/LO registers, and drives `exe_stall` back to ID/EX so the EX instruction is held while an operation is in flight. It also services MTHI/MTLO writes.

---
 rtl/ex_muldiv.sv | 189 ++++++++++++++++++
 tb/tb_ex_muldiv.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv -- iterative multiply/divide unit for the execute stage.
//
// Runs MULT/MULTU with radix-2 shift-add and DIV/DIVU with radix-2 restoring
// division, one bit per cycle over 32 iterations. Owns the architectural HI/LO
// registers and services MTHI/MTLO writes. While an operation is in flight,
// exe_stall holds ID/EX and the earlier stages.
//
// Optional build macro:
//   MULDIV_FAST_MUL_EN  MULT/MULTU use a single-cycle 32x32 multiplier and go
//                       IDLE -> DONE directly. DIV/DIVU are unaffected.
//
// Ports:
//   clk         in   1   clock; all state updates on the rising edge
//   resetn      in   1   synchronous, active-low reset
//   start       in   1   EX holds a valid mult/div instruction
//   op          in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a       in  32   rs operand (multiplicand / dividend)
//   src_b       in  32   rt operand (multiplier / divisor)
//   hilo_we     in   2   [1] write HI, [0] write LO (MTHI/MTLO)
//   hilo_wdata  in  32   data for hilo_we
//   flush       in   1   aborts any in-flight operation, discards its result
//   exe_stall   out  1   combinational stall request to ID/EX
//   done        out  1   combinational; high during the DONE cycle
//   hi, lo      out 32   registered HI/LO

module ex_muldiv (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [1:0]  hilo_we,
  input  logic [31:0] hilo_wdata,
  input  logic        flush,
  output logic        exe_stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [63:0] work;       // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0] operand;    // |multiplicand| for mul, |divisor| for div
  logic [31:0] raw_a;      // unmodified dividend, returned in HI on divide-by-zero
  logic        is_div;
  logic        neg_res;    // signed op with differing operand signs
  logic        neg_rem;    // signed op with a negative dividend
  logic        div_zero;

  // Operand conditioning at acceptance time.
  logic        op_signed;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic        accept;

  assign op_signed = ~op[0];
  assign a_abs     = (op_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
  assign b_abs     = (op_signed && src_b[31]) ? (32'd0 - src_b) : src_b;
  assign accept    = (state == S_IDLE) && start && !flush;

  assign exe_stall = !flush && (((state == S_IDLE) && start) ||
                                (state == S_MUL) || (state == S_DIV));
  assign done      = (state == S_DONE) && !flush;

  // One iteration of each algorithm.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_rem;
  logic [32:0] div_diff;
  logic [63:0] div_next;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    mul_sum  = {1'b0, work[63:32]};
    if (work[0]) mul_sum = {1'b0, work[63:32]} + {1'b0, operand};
    mul_next = {mul_sum, work[31:1]};

    // Remainder shifted left by one, including the bit that may overflow 32.
    div_rem  = work[63:31];
    div_diff = div_rem - {1'b0, operand};
    if (div_rem >= {1'b0, operand})
      div_next = {div_diff[31:0], work[30:0], 1'b1};
    else
      div_next = {work[62:0], 1'b0};
  end

  // Sign correction applied in DONE, written to HI/LO on the closing edge.
  logic [63:0] prod_fix;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_comb begin
    prod_fix = neg_res ? (64'd0 - work) : work;
    res_hi   = prod_fix[63:32];
    res_lo   = prod_fix[31:0];
    if (is_div) begin
      if (div_zero) begin
        res_hi = raw_a;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_lo = neg_res ? (32'd0 - work[31:0])  : work[31:0];
        res_hi = neg_rem ? (32'd0 - work[63:32]) : work[63:32];
      end
    end
  end

  // Control state and architectural HI/LO.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff reads the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= 6'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt <= 6'd0;
            if (op[1]) begin
              state <= S_DIV;
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              state <= S_DONE;
`else
              state <= S_MUL;
`endif
            end
          end else begin
            if (hilo_we[1]) hi <= hilo_wdata;
            if (hilo_we[0]) lo <= hilo_wdata;
          end
        end
        S_MUL, S_DIV: begin
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= S_DONE;
        end
        S_DONE: begin
          hi    <= res_hi;
          lo    <= res_lo;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath registers.
  // NOTE: these carry no reset; they are always loaded on acceptance before
  // being read, and the control FSM alone decides whether a result is used.
  always_ff @(posedge clk) begin
    if (accept) begin
      raw_a    <= src_a;
      is_div   <= op[1];
      neg_res  <= op_signed && (src_a[31] ^ src_b[31]);
      neg_rem  <= op_signed && src_a[31];
      div_zero <= (src_b == 32'd0);
      if (op[1]) begin
        operand <= b_abs;
        work    <= {32'd0, a_abs};
      end else begin
        operand <= a_abs;
`ifdef MULDIV_FAST_MUL_EN
        work    <= {32'd0, a_abs} * {32'd0, b_abs};
`else
        work    <= {32'd0, b_abs};
`endif
      end
    end else if (state == S_MUL) begin
      work <= mul_next;
    end else if (state == S_DIV) begin
      work <= div_next;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv -- directed self-checking bench for ex_muldiv.
// Inputs change after rising edges; outputs are sampled 1 ns later.

module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [1:0]  hilo_we;
  logic [31:0] hilo_wdata;
  logic        flush;
  logic        exe_stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_STALL = 1;
`else
  localparam int MUL_STALL = 33;
`endif
  localparam int DIV_STALL = 33;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  ex_muldiv dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .hilo_we    (hilo_we),
    .hilo_wdata (hilo_wdata),
    .flush      (flush),
    .exe_stall  (exe_stall),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Counts stall cycles until done is seen, then steps past the DONE edge.
  // Returns 1 ns after that edge, start still driven by the caller.
  task automatic wait_done(input string tag, output int st, output int dn);
    int  budget;
    bit  seen;
    st = 0; dn = 0; budget = 0; seen = 1'b0;
    while (!seen && budget < 100) begin
      #1;
      if (exe_stall) st++;
      if (done) begin
        dn++;
        seen = 1'b1;
      end else begin
        @(posedge clk);
      end
      budget++;
    end
    if (!seen) check({tag, "_timeout"}, 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
  endtask

  task automatic do_op(input string tag, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input int exp_st, input logic [31:0] eh, input logic [31:0] el,
                       input bit keep_start);
    int st, dn;
    drive_op(o, a, b);
    wait_done(tag, st, dn);
    if (!keep_start) start = 1'b0;
    check({tag, "_stall"}, 64'(st), 64'(exp_st));
    check({tag, "_done"}, 64'(dn), 64'd1);
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, el});
  endtask

  initial begin
    int st, dn;
    resetn = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    hilo_we = 2'b00; hilo_wdata = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_stall", {63'd0, exe_stall}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Signed multiply with differing signs.
    do_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, MUL_STALL, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    check("mult_neg_done_once", {63'd0, done}, 64'd0);
    // Division and sign rules.
    do_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_STALL, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    do_op("divu", OP_DIVU, 32'd7, 32'd2, DIV_STALL, 32'd1, 32'd3, 1'b0);
    do_op("divu_zero", OP_DIVU, 32'h1234_5678, 32'd0, DIV_STALL, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
    do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_STALL, 32'd0, 32'h8000_0000, 1'b0);
    do_op("div_zero", OP_DIV, 32'hFFFF_FFF9, 32'd0, DIV_STALL, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);
    do_op("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, MUL_STALL, 32'h4000_0000, 32'd0, 1'b0);

    // MTHI in IDLE.
    hilo_we = 2'b10; hilo_wdata = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    hilo_we = 2'b00;
    check("mthi_hi", {32'd0, hi}, {32'd0, 32'hA5A5_A5A5});
    check("mthi_lo", {32'd0, lo}, 64'd0);

    // hilo_we together with start: the write is dropped, the op runs.
    hilo_we = 2'b11; hilo_wdata = 32'h1111_1111;
    drive_op(OP_MULTU, 32'd3, 32'd5);
    @(posedge clk);
    #1;
    hilo_we = 2'b00;
    check("we_start_hi", {32'd0, hi}, {32'd0, 32'hA5A5_A5A5});
    check("we_start_lo", {32'd0, lo}, 64'd0);
    wait_done("we_start", st, dn);
    start = 1'b0;
    check("we_start_stall", 64'(st), 64'(MUL_STALL - 1));
    check("we_start_res_hi", {32'd0, hi}, 64'd0);
    check("we_start_res_lo", {32'd0, lo}, 64'd15);

    // Back-to-back: second start is held through DONE and taken the next cycle.
    do_op("b2b_1", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_STALL, 32'hFFFF_FFFE, 32'd1, 1'b1);
    do_op("b2b_2", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_STALL, 32'hFFFF_FFFE, 32'd1, 1'b0);

    // Flush at T10 of a DIVU.
    drive_op(OP_DIVU, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    check("flush_stall_t10", {63'd0, exe_stall}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; start = 1'b0;
    #1;
    check("flush_idle_stall", {63'd0, exe_stall}, 64'd0);
    check("flush_idle_done", {63'd0, done}, 64'd0);
    check("flush_hi", {32'd0, hi}, {32'd0, 32'hFFFF_FFFE});
    check("flush_lo", {32'd0, lo}, 64'd1);
    do_op("after_flush", OP_DIVU, 32'd100, 32'd7, DIV_STALL, 32'd2, 32'd14, 1'b0);

    // Reset at T5 of a new op: HI/LO cleared and no late write.
    drive_op(OP_DIVU, 32'd100, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0; start = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    check("rst_mid_hi", {32'd0, hi}, 64'd0);
    check("rst_mid_lo", {32'd0, lo}, 64'd0);
    check("rst_mid_stall", {63'd0, exe_stall}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("rst_mid_late_hi", {32'd0, hi}, 64'd0);
    check("rst_mid_late_lo", {32'd0, lo}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
